// File: rtl/ahb_pkg.sv
// Shared AHB types: transfer/burst encodings, arbiter states and burst length decode.
package ahb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      NONSEQ = 2'd2,
      SEQ    = 2'd3
   } htrans_t;

   typedef enum logic [2:0] {
      SINGLE = 3'd0,
      INCR   = 3'd1,
      WRAP4  = 3'd2,
      INCR4  = 3'd3,
      WRAP8  = 3'd4,
      INCR8  = 3'd5,
      WRAP16 = 3'd6,
      INCR16 = 3'd7
   } hburst_t;

   typedef enum logic [1:0] {
      StArb,
      StBurst,
      StLock
   } arb_state_t;

   // Beat count of a fixed-length burst; SINGLE and undefined-length INCR report 1.
   function automatic logic [4:0] burst_len(hburst_t burst);
      case (burst)
         WRAP4, INCR4:   burst_len = 5'd4;
         WRAP8, INCR8:   burst_len = 5'd8;
         WRAP16, INCR16: burst_len = 5'd16;
         default:        burst_len = 5'd1;
      endcase
   endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Rotate-priority picker: first set request bit searching upward from ptr_i+1 (mod N).
module ahb_rr_pick #(
   parameter int unsigned N = 4,
   localparam int unsigned W = $clog2(N)
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic [W-1:0] idx_o,
   output logic         found_o
);

   int unsigned   pos;
   logic [W-1:0]  pos_w;

   // Walk N positions starting just after the pointer; the pointer itself is checked last.
   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      pos     = 0;
      pos_w   = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         pos   = (32'(ptr_i) + k) % N;
         pos_w = W'(pos);
         if (!found_o && req_i[pos_w]) begin
            found_o = 1'b1;
            idx_o   = pos_w;
         end
      end
   end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter. Grant is held while a fixed-length burst still has two or
// more address phases to go, or while the granted master asserts HLOCK.
module ahb_arbiter
   import ahb_pkg::*;
#(
   parameter int unsigned NUM_MASTERS    = 4,
   parameter int unsigned DEFAULT_MASTER = 0,
   localparam int unsigned MW            = $clog2(NUM_MASTERS)
) (
   input  logic                   HCLK,
   input  logic                   HRESET,
   input  logic [NUM_MASTERS-1:0] HBUSREQ,
   input  logic [NUM_MASTERS-1:0] HLOCK,
   input  logic [1:0]             HTRANS,
   input  logic [2:0]             HBURST,
   input  logic                   HREADY,
   output logic [NUM_MASTERS-1:0] HGRANT,
   output logic [MW-1:0]          HMASTER,
   output logic                   HMASTLOCK
);

   localparam logic [MW-1:0]          DefIdx = MW'(DEFAULT_MASTER);
   localparam logic [NUM_MASTERS-1:0] DefGnt = NUM_MASTERS'(1) << DEFAULT_MASTER;

   arb_state_t    state_q, state_d;
   logic [4:0]    rem_q, rem_d;
   logic [MW-1:0] gnt_idx_q, gnt_idx_d;
   logic [MW-1:0] rr_ptr_q, rr_ptr_d;
   logic [MW-1:0] pick_idx;
   logic          pick_found;
   logic          owner_lock;
   logic          hold;

   ahb_rr_pick #(
      .N (NUM_MASTERS)
   ) u_pick (
      .req_i   (HBUSREQ),
      .ptr_i   (rr_ptr_q),
      .idx_o   (pick_idx),
      .found_o (pick_found)
   );

   // Burst counter update, hold decision and picker-driven grant selection.
   always_comb begin
      owner_lock = HLOCK[gnt_idx_q];
      rem_d      = rem_q;
      unique case (htrans_t'(HTRANS))
         // A NONSEQ inside a running burst is an early termination, not a new burst.
         NONSEQ:  rem_d = (state_q == StBurst) ? 5'd0 : burst_len(hburst_t'(HBURST)) - 5'd1;
         SEQ:     if (rem_q != 5'd0) rem_d = rem_q - 5'd1;
         IDLE:    rem_d = 5'd0;
         default: rem_d = rem_q;
      endcase

      // Releasing at remaining==1 moves the grant during the last beat's address phase.
      hold = (rem_d >= 5'd2) || owner_lock;

      if (owner_lock)           state_d = StLock;
      else if (rem_d >= 5'd2)   state_d = StBurst;
      else                      state_d = StArb;

      gnt_idx_d = gnt_idx_q;
      rr_ptr_d  = rr_ptr_q;
      if (!hold) begin
         if (pick_found) begin
            gnt_idx_d = pick_idx;
            rr_ptr_d  = pick_idx;
         end else begin
            gnt_idx_d = DefIdx;
         end
      end
   end

   // All state and outputs advance only on edges where the bus accepts an address phase.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q   <= StArb;
         rem_q     <= 5'd0;
         gnt_idx_q <= DefIdx;
         rr_ptr_q  <= DefIdx;
         HGRANT    <= DefGnt;
         HMASTER   <= DefIdx;
         HMASTLOCK <= 1'b0;
      end else if (HREADY) begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         gnt_idx_q <= gnt_idx_d;
         rr_ptr_q  <= rr_ptr_d;
         HGRANT    <= NUM_MASTERS'(1) << gnt_idx_d;
         HMASTER   <= gnt_idx_q;
         HMASTLOCK <= owner_lock;
      end
   end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Table-driven bench for ahb_arbiter with a scoreboard of expected registered outputs.
module tb_ahb_arbiter;
   import ahb_pkg::*;

   localparam int unsigned N = 4;

   logic          HCLK = 1'b0;
   logic          HRESET = 1'b1;
   logic [N-1:0]  HBUSREQ = '0;
   logic [N-1:0]  HLOCK = '0;
   logic [1:0]    HTRANS = 2'd0;
   logic [2:0]    HBURST = 3'd0;
   logic          HREADY = 1'b1;
   logic [N-1:0]  HGRANT;
   logic [1:0]    HMASTER;
   logic          HMASTLOCK;

   ahb_arbiter #(
      .NUM_MASTERS    (N),
      .DEFAULT_MASTER (0)
   ) dut (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .HBUSREQ   (HBUSREQ),
      .HLOCK     (HLOCK),
      .HTRANS    (HTRANS),
      .HBURST    (HBURST),
      .HREADY    (HREADY),
      .HGRANT    (HGRANT),
      .HMASTER   (HMASTER),
      .HMASTLOCK (HMASTLOCK)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic       rst;
      logic       async_chk;
      logic [3:0] req;
      logic [3:0] lck;
      htrans_t    tr;
      hburst_t    bu;
      logic       rdy;
      logic [3:0] eg;
      logic [1:0] em;
      logic       el;
   } vec_t;

   typedef struct {
      logic [3:0] g;
      logic [1:0] m;
      logic       l;
      int         id;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic add(input logic rst, input logic ac, input logic [3:0] req,
                      input logic [3:0] lck, input htrans_t tr, input hburst_t bu,
                      input logic rdy, input logic [3:0] eg, input logic [1:0] em,
                      input logic el);
      vec_t v;
      v.rst = rst; v.async_chk = ac; v.req = req; v.lck = lck; v.tr = tr; v.bu = bu;
      v.rdy = rdy; v.eg = eg; v.em = em; v.el = el;
      vecs.push_back(v);
   endtask

   task automatic check_out();
      exp_t e;
      n_cmp++;
      if (sb.size() == 0) begin
         n_bad++;
         $display("FAIL scoreboard_empty: got nothing, required one expected entry");
      end else begin
         e = sb.pop_front();
         if (HGRANT !== e.g || HMASTER !== e.m || HMASTLOCK !== e.l) begin
            n_bad++;
            $display("FAIL vec%0d: got HGRANT=%b HMASTER=%0d HMASTLOCK=%b, required %b/%0d/%b",
                     e.id, HGRANT, HMASTER, HMASTLOCK, e.g, e.m, e.l);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   cyc;
      logic got;
      exp_t e;

      // Reset values, asynchronously and across an edge.
      add(1'b1, 1'b1, 4'h0, 4'h0, IDLE, SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
      add(1'b1, 1'b0, 4'h0, 4'h0, IDLE, SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
      // Idle: park on the default master.
      for (int i = 0; i < 10; i++)
         add(1'b0, 1'b0, 4'h0, 4'h0, IDLE, SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
      // Round-robin with all masters requesting singles.
      add(1'b0, 1'b0, 4'hF, 4'h0, NONSEQ, SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0);
      add(1'b0, 1'b0, 4'hF, 4'h0, NONSEQ, SINGLE, 1'b1, 4'b0100, 2'd1, 1'b0);
      add(1'b0, 1'b0, 4'hF, 4'h0, NONSEQ, SINGLE, 1'b1, 4'b1000, 2'd2, 1'b0);
      add(1'b0, 1'b0, 4'hF, 4'h0, NONSEQ, SINGLE, 1'b1, 4'b0001, 2'd3, 1'b0);
      add(1'b0, 1'b0, 4'hF, 4'h0, NONSEQ, SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0);
      // INCR4 by master 2 with master 3 waiting.
      add(1'b0, 1'b0, 4'b0100, 4'h0, IDLE,   SINGLE, 1'b1, 4'b0100, 2'd1, 1'b0);
      add(1'b0, 1'b0, 4'b0100, 4'h0, IDLE,   SINGLE, 1'b1, 4'b0100, 2'd2, 1'b0);
      add(1'b0, 1'b0, 4'b1100, 4'h0, NONSEQ, INCR4,  1'b1, 4'b0100, 2'd2, 1'b0);
      add(1'b0, 1'b0, 4'b1100, 4'h0, SEQ,    INCR4,  1'b1, 4'b0100, 2'd2, 1'b0);
      add(1'b0, 1'b0, 4'b1100, 4'h0, SEQ,    INCR4,  1'b1, 4'b1000, 2'd2, 1'b0);
      add(1'b0, 1'b0, 4'b1000, 4'h0, SEQ,    INCR4,  1'b1, 4'b1000, 2'd3, 1'b0);
      // INCR8 by master 3 with three wait states and one BUSY.
      add(1'b0, 1'b0, 4'b1001, 4'h0, NONSEQ, INCR8, 1'b1, 4'b1000, 2'd3, 1'b0);
      add(1'b0, 1'b0, 4'b1001, 4'h0, SEQ,    INCR8, 1'b1, 4'b1000, 2'd3, 1'b0);
      for (int i = 0; i < 3; i++)
         add(1'b0, 1'b0, 4'b1001, 4'h0, SEQ, INCR8, 1'b0, 4'b1000, 2'd3, 1'b0);
      add(1'b0, 1'b0, 4'b1001, 4'h0, SEQ,    INCR8, 1'b1, 4'b1000, 2'd3, 1'b0);
      add(1'b0, 1'b0, 4'b1001, 4'h0, BUSY,   INCR8, 1'b1, 4'b1000, 2'd3, 1'b0);
      for (int i = 0; i < 3; i++)
         add(1'b0, 1'b0, 4'b1001, 4'h0, SEQ, INCR8, 1'b1, 4'b1000, 2'd3, 1'b0);
      add(1'b0, 1'b0, 4'b1001, 4'h0, SEQ,    INCR8, 1'b1, 4'b0001, 2'd3, 1'b0);
      add(1'b0, 1'b0, 4'b0001, 4'h0, SEQ,    INCR8, 1'b1, 4'b0001, 2'd0, 1'b0);
      // HREADY low freezes rotation in ARB.
      add(1'b0, 1'b0, 4'hF, 4'h0, IDLE, SINGLE, 1'b0, 4'b0001, 2'd0, 1'b0);
      add(1'b0, 1'b0, 4'hF, 4'h0, IDLE, SINGLE, 1'b0, 4'b0001, 2'd0, 1'b0);
      add(1'b0, 1'b0, 4'hF, 4'h0, IDLE, SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0);
      // Master 1 locked for five singles, then releases.
      for (int i = 0; i < 5; i++)
         add(1'b0, 1'b0, 4'hF, 4'b0010, NONSEQ, SINGLE, 1'b1, 4'b0010, 2'd1, 1'b1);
      add(1'b0, 1'b0, 4'hF, 4'h0, NONSEQ, SINGLE, 1'b1, 4'b0100, 2'd1, 1'b0);
      add(1'b0, 1'b0, 4'hF, 4'h0, NONSEQ, SINGLE, 1'b1, 4'b1000, 2'd2, 1'b0);
      // WRAP16 by master 3, reset during beat 7.
      add(1'b0, 1'b0, 4'b1000, 4'h0, IDLE,   SINGLE, 1'b1, 4'b1000, 2'd3, 1'b0);
      add(1'b0, 1'b0, 4'b1001, 4'h0, NONSEQ, WRAP16, 1'b1, 4'b1000, 2'd3, 1'b0);
      for (int i = 0; i < 5; i++)
         add(1'b0, 1'b0, 4'b1001, 4'h0, SEQ, WRAP16, 1'b1, 4'b1000, 2'd3, 1'b0);
      add(1'b1, 1'b1, 4'b1001, 4'h0, SEQ, WRAP16, 1'b1, 4'b0001, 2'd0, 1'b0);
      add(1'b1, 1'b0, 4'b1001, 4'h0, SEQ, WRAP16, 1'b1, 4'b0001, 2'd0, 1'b0);
      add(1'b0, 1'b0, 4'b1001, 4'h0, SEQ, WRAP16, 1'b1, 4'b1000, 2'd0, 1'b0);
      add(1'b0, 1'b0, 4'b1001, 4'h0, SEQ, WRAP16, 1'b1, 4'b0001, 2'd3, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge HCLK);
         HRESET  = vecs[i].rst;
         HBUSREQ = vecs[i].req;
         HLOCK   = vecs[i].lck;
         HTRANS  = vecs[i].tr;
         HBURST  = vecs[i].bu;
         HREADY  = vecs[i].rdy;
         e.g = vecs[i].eg; e.m = vecs[i].em; e.l = vecs[i].el; e.id = i;
         sb.push_back(e);
         if (vecs[i].async_chk) begin
            #1;
         end else begin
            @(posedge HCLK);
            #1;
         end
         check_out();
      end

      // Request-to-grant latency: a lone new requester is granted after one edge.
      @(negedge HCLK);
      HBUSREQ = 4'b0100;
      HLOCK   = 4'h0;
      HTRANS  = IDLE;
      HBURST  = SINGLE;
      HREADY  = 1'b1;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 4) begin
         @(posedge HCLK);
         #1;
         cyc++;
         if (HGRANT == 4'b0100) got = 1'b1;
      end
      n_cmp++;
      if (!got || cyc != 1) begin
         n_bad++;
         $display("FAIL req_to_grant: got %0d cycles (granted=%b), required 1 cycle", cyc, got);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
